// File: rtl/decode_queue.sv
// decode_queue: credit-tracked FIFO between fetch responses and decode; flush kills queued and in-flight entries.
// Define DECODE_QUEUE_BYPASS_EN to present a live response on an empty queue in the same cycle.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int MEM_LAT = 2,
  parameter int EXC_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         halt,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [31:0]                  in_instr,
  input  logic [31:0]                  in_pc,
  input  logic [EXC_W-1:0]             in_exc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic [EXC_W-1:0]             out_exc,
  output logic                         fetch_stall,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [EXC_W-1:0] exc_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MEM_LAT-1:0] iss_q, iss_d, live_q, live_d;
  logic ovf_q, ovf_d;
  logic active, accept, byp, has, push, pop, full, wr_en;
  logic [CW:0] inflight;
  assign active = clk_en && !halt;
  assign accept = in_valid && iss_q[MEM_LAT-1] && live_q[MEM_LAT-1];
  assign has = cnt_q != '0;
`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = accept && !has && out_ready;
`else
  assign byp = 1'b0;
`endif
  assign push = accept && !byp;
  assign pop = has && out_ready;
  assign full = cnt_q == CW'(DEPTH);
  // a full queue still accepts a push when the head leaves in the same cycle
  assign wr_en = active && !flush && push && (!full || pop);
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + (CW+1)'(iss_q[i]);
  end
  // killed issues keep their credit until they drain out of the tracker
  assign fetch_stall = ({1'b0, cnt_q} + inflight) >= (CW+1)'(DEPTH);
  always_comb begin
    iss_d = iss_q;
    live_d = live_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (active) begin
      for (int i = MEM_LAT-1; i > 0; i--) begin
        iss_d[i] = iss_q[i-1];
        live_d[i] = live_q[i-1] && !flush;
      end
      iss_d[0] = !fetch_stall;
      live_d[0] = !flush;
      if (flush) begin
        wr_d = '0;
        rd_d = '0;
        cnt_d = '0;
      end else begin
        wr_d = wr_en ? wr_q + PW'(1) : wr_q;
        rd_d = pop ? rd_q + PW'(1) : rd_q;
        cnt_d = (wr_en && !pop) ? cnt_q + CW'(1) : (pop && !wr_en) ? cnt_q - CW'(1) : cnt_q;
        ovf_d = ovf_q || (push && full && !pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q <= '0;
      live_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      iss_q <= iss_d;
      live_q <= live_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      instr_q[wr_q] <= in_instr;
      pc_q[wr_q] <= in_pc;
      exc_q[wr_q] <= in_exc;
    end
  end
  always_comb begin
    out_valid = has || byp;
    out_instr = byp ? in_instr : has ? instr_q[rd_q] : '0;
    out_pc = byp ? in_pc : has ? pc_q[rd_q] : '0;
    out_exc = byp ? in_exc : has ? exc_q[rd_q] : '0;
  end
  assign count = cnt_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: phase table drives a fetch-memory model; a scoreboard checks every head entry each cycle.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int MEM_LAT = 2;
  localparam int EXC_W = 8;
  localparam int CW = $clog2(DEPTH+1);
  localparam int L = MEM_LAT - 1;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, halt = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [EXC_W-1:0] in_exc = '0;
  logic out_valid, fetch_stall, overflow_err;
  logic [31:0] out_instr, out_pc;
  logic [EXC_W-1:0] out_exc;
  logic [CW-1:0] count;
  always #5 clk = ~clk;
  decode_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
    .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_exc(out_exc), .fetch_stall(fetch_stall),
    .count(count), .overflow_err(overflow_err)
  );
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [EXC_W-1:0] exc; } ent_t;
  typedef struct { int n; bit rdy; bit fl; bit hl; bit en; bit rs; bit fo; logic [31:0] redir; int ecnt; bit estall; bit eovf; } vec_t;
  ent_t sb[$];
  vec_t tab[$];
  bit pv[MEM_LAT], pcr[MEM_LAT], pl[MEM_LAT];
  logic [31:0] ppc[MEM_LAT];
  logic [31:0] pc_next = '0;
  bit exp_ovf = 1'b0;
  int n_cmp = 0, n_bad = 0;
  function automatic ent_t mk(logic [31:0] pc);
    ent_t r;
    r.instr = pc ^ 32'h1357_9bdf;
    r.pc = pc;
    r.exc = pc[9:2];
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(int n, bit rdy, bit fl, bit hl, bit en, bit rs, bit fo, logic [31:0] redir, int ecnt, bit estall, bit eovf);
    vec_t v;
    v.n = n; v.rdy = rdy; v.fl = fl; v.hl = hl; v.en = en; v.rs = rs; v.fo = fo;
    v.redir = redir; v.ecnt = ecnt; v.estall = estall; v.eovf = eovf;
    tab.push_back(v);
  endtask
  task automatic cycle(bit rdy, bit fl, bit hl, bit en, bit rs, bit fo, logic [31:0] redir);
    int cred;
    bit stall, issue, act;
    ent_t e, r;
    @(negedge clk);
    cred = 0;
    for (int i = 0; i < MEM_LAT; i++) cred += int'(pcr[i]);
    stall = (sb.size() + cred) >= DEPTH;
    e = '{instr: '0, pc: '0, exc: '0};
    if (sb.size() != 0) e = sb[0];
    chk("count", 32'(count), 32'(sb.size()));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("out_instr", out_instr, e.instr);
    chk("out_pc", out_pc, e.pc);
    chk("out_exc", 32'(out_exc), 32'(e.exc));
    chk("fetch_stall", 32'(fetch_stall), 32'(stall));
    chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
    r = mk(ppc[L]);
    out_ready = rdy; flush = fl; halt = hl; clk_en = en; rst = rs;
    in_valid = pv[L];
    in_instr = pv[L] ? r.instr : '0;
    in_pc = pv[L] ? r.pc : '0;
    in_exc = pv[L] ? r.exc : '0;
    act = en && !hl;
    issue = !rs && act && (fo || !stall);
    if (fo) force dut.fetch_stall = 1'b0;
    if (rs) begin
      sb.delete();
      exp_ovf = 1'b0;
      for (int i = L; i > 0; i--) begin
        pv[i] = pv[i-1]; pcr[i] = 1'b0; pl[i] = 1'b0; ppc[i] = ppc[i-1];
      end
      pv[0] = 1'b0; pcr[0] = 1'b0; pl[0] = 1'b0;
    end else if (act) begin
      if (fl) sb.delete();
      else begin
        if (sb.size() != 0 && rdy) void'(sb.pop_front());
        if (pv[L] && pcr[L] && pl[L]) begin
          if (sb.size() < DEPTH) sb.push_back(mk(ppc[L]));
          else exp_ovf = 1'b1;
        end
      end
      for (int i = L; i > 0; i--) begin
        pv[i] = pv[i-1]; pcr[i] = pcr[i-1]; pl[i] = pl[i-1] && !fl; ppc[i] = ppc[i-1];
      end
      pv[0] = issue; pcr[0] = issue; pl[0] = !fl; ppc[0] = pc_next;
      pc_next = fl ? redir : issue ? pc_next + 32'd4 : pc_next;
    end
    @(posedge clk);
    #1;
    if (fo) release dut.fetch_stall;
  endtask
  initial begin
    for (int i = 0; i < MEM_LAT; i++) begin
      pv[i] = 1'b0; pcr[i] = 1'b0; pl[i] = 1'b0; ppc[i] = '0;
    end
    //  n  rdy fl hl en rs fo redir      cnt stall ovf
    add(2,  1, 0, 0, 1, 1, 0, 32'h0,    0, 0, 0);
    add(18, 1, 0, 0, 1, 0, 0, 32'h0,    1, 0, 0);
    add(10, 0, 0, 0, 1, 0, 0, 32'h0,    4, 1, 0);
    add(20, 1, 0, 0, 1, 0, 0, 32'h0,    1, 0, 0);
    add(6,  0, 0, 0, 1, 0, 0, 32'h0,    4, 1, 0);
    add(1,  0, 0, 0, 1, 0, 1, 32'h0,    4, 1, 0);
    add(1,  0, 0, 0, 1, 0, 0, 32'h0,    4, 1, 0);
    add(1,  1, 0, 0, 1, 0, 0, 32'h0,    4, 1, 0);
    add(1,  0, 0, 0, 1, 0, 1, 32'h0,    4, 1, 0);
    add(1,  0, 0, 0, 1, 0, 0, 32'h0,    4, 1, 0);
    add(1,  0, 0, 0, 1, 0, 0, 32'h0,    4, 1, 1);
    add(8,  1, 0, 0, 1, 0, 0, 32'h0,    1, 0, 1);
    add(1,  1, 1, 0, 1, 0, 0, 32'h100,  0, 0, 1);
    add(2,  1, 0, 0, 1, 0, 0, 32'h0,    0, 0, 1);
    add(1,  1, 1, 0, 1, 0, 0, 32'h200,  0, 0, 1);
    add(6,  1, 0, 0, 1, 0, 0, 32'h0,    1, 0, 1);
    add(3,  1, 0, 1, 1, 0, 0, 32'h0,    1, 0, 1);
    add(2,  1, 0, 0, 0, 0, 0, 32'h0,    1, 0, 1);
    add(3,  1, 0, 0, 1, 0, 0, 32'h0,    1, 0, 1);
    add(2,  0, 0, 0, 1, 0, 0, 32'h0,    3, 1, 1);
    add(1,  0, 0, 0, 1, 1, 0, 32'h0,    0, 0, 0);
    add(4,  1, 0, 0, 1, 0, 0, 32'h0,    1, 0, 0);
    add(1,  1, 0, 0, 1, 1, 0, 32'h0,    0, 0, 0);
    add(4,  1, 0, 0, 1, 0, 0, 32'h0,    1, 0, 0);
    for (int k = 0; k < tab.size(); k++) begin
      for (int c = 0; c < tab[k].n; c++)
        cycle(tab[k].rdy, tab[k].fl, tab[k].hl, tab[k].en, tab[k].rs, tab[k].fo, tab[k].redir);
      #2;
      chk($sformatf("p%0d_count", k), 32'(count), 32'(tab[k].ecnt));
      chk($sformatf("p%0d_fetch_stall", k), 32'(fetch_stall), 32'(tab[k].estall));
      chk($sformatf("p%0d_overflow_err", k), 32'(overflow_err), 32'(tab[k].eovf));
    end
    cycle(1, 0, 0, 1, 0, 0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
